instruction_fetch_unit: RTL

Producer end of the instruction-register interface. Holds the program counter, drives a synchronous-read program ROM, and presents each fetched 22-bit word together with an `increment` strobe and an `is_void` flag to the downstream instruction register. `is_void` = 1 marks a bubble, which the register turns into a clear-carry NOP. The unit inserts bubbles after reset, after jumps and while halted, so no wrong-path word is ever issued as valid.

---
 rtl/instruction_fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, synchronous-ROM pipeline and issue registers feeding the instruction register.
// Bubbles (is_void=1) cover reset, jump and halt so no wrong-path word is ever issued valid.
module instruction_fetch_unit #(
  parameter int ADDR_W       = 10,
  parameter int INS_W        = 22,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [INS_W-1:0]  rom_data,
  output logic [INS_W-1:0]  ins_out,
  output logic              increment,
  output logic              is_void,
  output logic [ADDR_W-1:0] pc_issue,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic              v_d;

  assign rom_addr = pc;
  assign rom_en   = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= ADDR_W'(RESET_VECTOR);
      pc_d      <= '0;
      v_d       <= 1'b0;
      state     <= RUN;
      ins_out   <= '0;
      increment <= 1'b0;
      is_void   <= 1'b1;
      pc_issue  <= '0;
      halted    <= 1'b0;
    end else if (stall) begin
      increment <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          ins_out   <= rom_data;
          pc_issue  <= pc_d;
          increment <= 1'b1;
          pc_d      <= pc;
          if (jump_en) begin
            is_void <= 1'b1;
            pc      <= jump_addr;
            v_d     <= 1'b0;
          end else if (halt) begin
            is_void <= ~v_d;
            v_d     <= 1'b1;
            state   <= HALTED;
            halted  <= 1'b1;
          end else begin
            is_void <= ~v_d;
            pc      <= pc + ADDR_W'(1);
            v_d     <= 1'b1;
          end
        end
        HALTED: begin
          increment <= 1'b1;
          if (resume) begin
            ins_out  <= rom_data;
            is_void  <= 1'b0;
            pc_issue <= pc_d;
            pc       <= pc + ADDR_W'(1);
            pc_d     <= pc;
            // The ROM re-reads mem[pc] on this edge, so the word behind rom_data is a repeat.
            v_d      <= 1'b0;
            state    <= RUN;
            halted   <= 1'b0;
          end else begin
            is_void <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
